// File: rtl/approx_add_pkg.sv
// Shared types and helpers for the sequenced nibble adder.
// Contents:
//   state_e     - controller states (idle, running nibbles, result held)
//   nib_mode_e  - per-nibble rule: exact add or TT3 approximation
//   clamp_nibs  - limits the requested approximate nibble count to the nibble total
package approx_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic {
    NibExact = 1'b0,
    NibTt3   = 1'b1
  } nib_mode_e;

  function automatic int unsigned clamp_nibs(input int unsigned n, input int unsigned nib);
    return (n > nib) ? nib : n;
  endfunction

endpackage

// File: rtl/approx_nib_slice.sv
// Combinational 4-bit adder slice with two rules.
// Ports:
//   a4_i, b4_i - operand nibbles
//   cin_i      - incoming carry (used by the exact rule only)
//   mode_i     - NibExact: {cout, s4} = a4 + b4 + cin
//                NibTt3:   s4 = b4, cout = a4[3]
//   s4_o       - nibble sum
//   cout_o     - outgoing carry
module approx_nib_slice
  import approx_add_pkg::*;
(
  input  logic [3:0] a4_i,
  input  logic [3:0] b4_i,
  input  logic       cin_i,
  input  nib_mode_e  mode_i,
  output logic [3:0] s4_o,
  output logic       cout_o
);

  logic [4:0] exact_sum;

  assign exact_sum = {1'b0, a4_i} + {1'b0, b4_i} + {4'b0, cin_i};

  always_comb begin
    s4_o   = exact_sum[3:0];
    cout_o = exact_sum[4];
    if (mode_i == NibTt3) begin
      // TT3 passes B through and forwards A's MSB as the carry.
      s4_o   = b4_i;
      cout_o = a4_i[3];
    end
  end

endmodule

// File: rtl/approx_add_seq_ctrl.sv
// Sequenced WIDTH-bit adder: one nibble slice reused over WIDTH/4 cycles.
// The lowest approx_nibs nibbles use the TT3 rule, the rest add exactly.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid / in_ready   - operand handshake (ready only while idle)
//   a, b, approx_nibs     - operands and approximate nibble count (clamped to WIDTH/4)
//   out_valid / out_ready - result handshake
//   sum                   - WIDTH+1 bit result, MSB is the final carry
//   busy                  - controller is not idle
module approx_add_seq_ctrl
  import approx_add_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned NIB  = WIDTH / 4,
  localparam int unsigned NW   = $clog2(NIB + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [NW-1:0]    approx_nibs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  state_e           state_q, state_d;
  // idx shares the width of n so the mode compare needs no extension.
  logic [NW-1:0]    idx_q, idx_d;
  logic [NW-1:0]    n_q, n_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic [3:0]       s4;
  logic             cout;
  nib_mode_e        mode;

  assign mode = (idx_q < n_q) ? NibTt3 : NibExact;

  approx_nib_slice u_slice (
    .a4_i  (a_q[4*idx_q +: 4]),
    .b4_i  (b_q[4*idx_q +: 4]),
    .cin_i (carry_q),
    .mode_i(mode),
    .s4_o  (s4),
    .cout_o(cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          n_d     = NW'(clamp_nibs(32'(approx_nibs), NIB));
          idx_d   = '0;
          carry_d = 1'b0;
          sum_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[4*idx_q +: 4] = s4;
        carry_d = cout;
        if (idx_q == NW'(NIB - 1)) begin
          sum_d[WIDTH] = cout;
          state_d      = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      n_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;

endmodule

// File: tb/tb_approx_add_seq_ctrl.sv
// Randomized self-checking bench for approx_add_seq_ctrl (WIDTH=32).
module tb_approx_add_seq_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned NB = W / 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    approx_nibs = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W:0]    sum;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  approx_add_seq_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .approx_nibs(approx_nibs),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: low k nibbles copy B, A's bit 4k-1 carries into an exact add of the upper part.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input int unsigned n);
    int unsigned k  = (n > NB) ? NB : n;
    int unsigned sh = 4 * k;
    logic [63:0] mask, lo, hi;
    if (k == 0) return (W+1)'(64'(x) + 64'(y));
    mask = (64'd1 << sh) - 64'd1;
    lo   = 64'(y) & mask;
    hi   = (64'(x) >> sh) + (64'(y) >> sh) + 64'(x[sh-1]);
    return (W+1)'((hi << sh) | lo);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic [3:0] n, input int stall, input string tag);
    logic [W:0] exp_sum;
    int cycles;
    exp_sum = model(op_a, op_b, 32'(n));
    check({tag, "_rdy_idle"}, 64'(in_ready), 64'd1);
    a = op_a; b = op_b; approx_nibs = n; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = $urandom(); b = $urandom(); approx_nibs = 4'($urandom());
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      if (in_ready) begin
        check({tag, "_rdy_run"}, 64'(in_ready), 64'd0);
      end
      tick();
      cycles++;
    end
    check({tag, "_lat"}, 64'(cycles), 64'(NB));
    check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_sum"}, 64'(sum), 64'(exp_sum));
      check({tag, "_hold_ov"}, 64'({out_valid, in_ready, busy}), 64'(3'b101));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_back_idle"}, 64'({out_valid, in_ready, busy}), 64'(3'b010));
  endtask

  initial begin
    #12;
    check("rst_state", 64'({out_valid, in_ready, busy}), 64'(3'b010));
    check("rst_sum", 64'(sum), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'd0, 0, "exact");
    check("exact_const", 64'(sum), 64'h1_0000_0000);
    run_op(32'h0000_00FF, 32'h0000_0001, 4'd2, 0, "partial");
    check("partial_const", 64'(sum), 64'h0_0000_0101);
    run_op(32'h8000_0000, 32'h1234_5678, 4'd8, 0, "full");
    check("full_const", 64'(sum), 64'h1_1234_5678);
    run_op(32'h8000_0000, 32'h1234_5678, 4'd15, 0, "clamp");
    check("clamp_const", 64'(sum), 64'h1_1234_5678);
    run_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 4'd3, 5, "bp");
    run_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 4'd0, 0, "after_bp");

    // Reset while idx==3: nothing of the partial op may surface.
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; approx_nibs = 4'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", 64'({out_valid, in_ready, busy}), 64'(3'b010));
    check("midrst_sum", 64'(sum), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 4'd1, 0, "post_rst");

    for (int t = 0; t < 24; t++) begin
      run_op($urandom(), $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 2), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
